// File: rtl/cpu_sequencer_pkg.sv
// Shared phase codes, HALT opcode and internal FSM encoding for the instruction-cycle sequencer.
package cpu_sequencer_pkg;

    localparam logic [1:0] FETCH      = 2'd0;
    localparam logic [1:0] DECODE     = 2'd1;
    localparam logic [1:0] EXECUTE    = 2'd2;
    localparam logic [1:0] WRITE_BACK = 2'd3;

    localparam logic [4:0] HALT = 5'h1F;

    typedef enum logic [2:0] {
        SEQ_IDLE       = 3'd0,
        SEQ_FETCH      = 3'd1,
        SEQ_DECODE     = 3'd2,
        SEQ_EXECUTE    = 3'd3,
        SEQ_WRITE_BACK = 3'd4,
        SEQ_FAULT      = 3'd5
    } seq_state_t;

    // Idle and fault report as FETCH so legacy consumers of the 2-bit phase see a legal code.
    function automatic logic [1:0] phase_of(input seq_state_t s);
        logic [1:0] p;
        p = FETCH;
        case (s)
            SEQ_DECODE:     p = DECODE;
            SEQ_EXECUTE:    p = EXECUTE;
            SEQ_WRITE_BACK: p = WRITE_BACK;
            default:        p = FETCH;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/cpu_sequencer_timeout.sv
// Fetch-wait watchdog: loadable down-counter, reloaded while clear is high,
// counts down on enable; expired flags the cycle that uses up the budget.
module cpu_sequencer_timeout #(
    parameter int unsigned IMEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned TO_W = (IMEM_TIMEOUT < 2) ? 1 : $clog2(IMEM_TIMEOUT + 1);
    localparam logic [TO_W-1:0] LOAD_VAL = TO_W'(IMEM_TIMEOUT);

    logic [TO_W-1:0] remaining;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            remaining <= '0;
        end else if (clear) begin
            remaining <= LOAD_VAL;
        end else if (enable && (remaining != '0)) begin
            remaining <= remaining - TO_W'(1);
        end
    end

    // A zero budget never expires, which is how the timeout is disabled.
    assign expired = (IMEM_TIMEOUT != 0) && enable && (remaining == TO_W'(1));

endmodule

// File: rtl/cpu_sequencer.sv
// Handshaked FETCH/DECODE/EXECUTE/WRITE_BACK controller with run/step debug,
// fetch-timeout fault and retired-instruction counter.
//
//   state          | meaning
//   ---------------+-----------------------------------------------
//   SEQ_IDLE       | halted, waiting for run or step
//   SEQ_FETCH      | imem_req high until imem_ready; ir_load on ready
//   SEQ_DECODE     | one cycle; HALT opcode returns to idle
//   SEQ_EXECUTE    | alu_start on first cycle; waits alu_done if multicycle
//   SEQ_WRITE_BACK | pc advance, register write, retire
//   SEQ_FAULT      | fetch timed out; sticky until reset
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int unsigned IMEM_TIMEOUT = 15,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 step,
    input  logic [4:0]           opcode,
    input  logic                 no_write,
    input  logic                 alu_multicycle,
    input  logic                 alu_done,
    input  logic                 imem_ready,
    output logic                 imem_req,
    output logic                 ir_load,
    output logic                 alu_start,
    output logic                 pc_enable,
    output logic                 reg_write_enable,
    output logic [1:0]           state,
    output logic                 halted,
    output logic                 fault,
    output logic [CNT_WIDTH-1:0] retired_count
);

    seq_state_t seq_state;
    seq_state_t seq_next;
    logic       exec_first;
    logic       fetch_wait;
    logic       fetch_expired;

    assign fetch_wait = (seq_state == SEQ_FETCH) && !imem_ready;

    cpu_sequencer_timeout #(
        .IMEM_TIMEOUT (IMEM_TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (seq_state != SEQ_FETCH),
        .enable  (fetch_wait),
        .expired (fetch_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seq_state  <= SEQ_IDLE;
            exec_first <= 1'b0;
        end else begin
            seq_state  <= seq_next;
            exec_first <= (seq_next == SEQ_EXECUTE) && (seq_state != SEQ_EXECUTE);
        end
    end

    always_comb begin
        seq_next         = seq_state;
        imem_req         = 1'b0;
        ir_load          = 1'b0;
        alu_start        = 1'b0;
        pc_enable        = 1'b0;
        reg_write_enable = 1'b0;
        halted           = 1'b0;
        fault            = 1'b0;
        case (seq_state)
            SEQ_IDLE: begin
                halted = 1'b1;
                if (run || step) seq_next = SEQ_FETCH;
            end
            SEQ_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_load  = 1'b1;
                    seq_next = SEQ_DECODE;
                end else if (fetch_expired) begin
                    seq_next = SEQ_FAULT;
                end
            end
            SEQ_DECODE: begin
                seq_next = (opcode == HALT) ? SEQ_IDLE : SEQ_EXECUTE;
            end
            SEQ_EXECUTE: begin
                alu_start = exec_first;
                if (!alu_multicycle || alu_done) seq_next = SEQ_WRITE_BACK;
            end
            SEQ_WRITE_BACK: begin
                pc_enable        = 1'b1;
                reg_write_enable = !no_write;
                seq_next         = run ? SEQ_FETCH : SEQ_IDLE;
            end
            SEQ_FAULT: begin
                halted = 1'b1;
                fault  = 1'b1;
            end
            default: begin
                seq_next = SEQ_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_count <= '0;
        end else if (seq_state == SEQ_WRITE_BACK) begin
            retired_count <= retired_count + CNT_WIDTH'(1);
        end
    end

    assign state = phase_of(seq_state);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: inputs change on the falling edge, outputs are checked 1ns later.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        step;
    logic [4:0]  opcode;
    logic        no_write;
    logic        alu_multicycle;
    logic        alu_done;
    logic        imem_ready;
    logic        imem_req;
    logic        ir_load;
    logic        alu_start;
    logic        pc_enable;
    logic        reg_write_enable;
    logic [1:0]  state;
    logic        halted;
    logic        fault;
    logic [31:0] retired_count;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    cpu_sequencer #(
        .IMEM_TIMEOUT (15),
        .CNT_WIDTH    (32)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .run              (run),
        .step             (step),
        .opcode           (opcode),
        .no_write         (no_write),
        .alu_multicycle   (alu_multicycle),
        .alu_done         (alu_done),
        .imem_ready       (imem_ready),
        .imem_req         (imem_req),
        .ir_load          (ir_load),
        .alu_start        (alu_start),
        .pc_enable        (pc_enable),
        .reg_write_enable (reg_write_enable),
        .state            (state),
        .halted           (halted),
        .fault            (fault),
        .retired_count    (retired_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; run = 1'b0; step = 1'b0; opcode = 5'h03; no_write = 1'b0;
        alu_multicycle = 1'b0; alu_done = 1'b0; imem_ready = 1'b0;
        repeat (3) cyc();
        reset = 1'b1;
        cyc(); #1;
        chk("rst_halted", 32'(halted), 32'd1);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_strobes", {27'd0, imem_req, ir_load, alu_start, pc_enable, reg_write_enable}, 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_retired", retired_count, 32'd0);

        // free-run, three back-to-back instructions, second one writes nothing
        cyc(); run = 1'b1; imem_ready = 1'b1; opcode = 5'h03;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            if (k == 12) run = 1'b0;
            no_write = (k == 8);
            #1;
            chk("run_state", 32'(state), 32'((k - 1) % 4));
            chk("run_pc_en", 32'(pc_enable), 32'(k % 4 == 0));
            chk("run_ir_load", 32'(ir_load), 32'(k % 4 == 1));
            if (k % 4 == 0) chk("run_reg_we", 32'(reg_write_enable), 32'(k != 8));
        end
        cyc(); no_write = 1'b0; #1;
        chk("run_stop_halted", 32'(halted), 32'd1);
        chk("run_retired", retired_count, 32'd3);

        // single step with a 5-cycle fetch stall
        cyc(); step = 1'b1; imem_ready = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            cyc(); step = 1'b0; imem_ready = (c == 6); #1;
            chk("stall_req", 32'(imem_req), 32'd1);
            chk("stall_ir_load", 32'(ir_load), 32'(c == 6));
        end
        cyc(); imem_ready = 1'b0; #1;
        chk("stall_decode", 32'(state), 32'(2'd1));
        chk("stall_req_off", 32'(imem_req), 32'd0);
        cyc(); cyc(); #1;
        chk("step_wb", 32'(pc_enable), 32'd1);
        cyc(); #1;
        chk("step_idle", 32'(halted), 32'd1);
        chk("step_retired", retired_count, 32'd4);

        // fetch timeout after 15 stalled cycles, sticky until reset
        cyc(); step = 1'b1; imem_ready = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            cyc(); step = 1'b0; #1;
            if (c == 1 || c == 15) begin
                chk("to_req", 32'(imem_req), 32'd1);
                chk("to_no_fault_yet", 32'(fault), 32'd0);
            end
        end
        cyc(); #1;
        chk("to_fault", 32'(fault), 32'd1);
        chk("to_halted", 32'(halted), 32'd1);
        chk("to_req_off", 32'(imem_req), 32'd0);
        run = 1'b1; step = 1'b1; imem_ready = 1'b1;
        repeat (5) cyc();
        #1;
        chk("to_sticky", 32'(fault), 32'd1);
        chk("to_state", 32'(state), 32'd0);
        chk("to_retired", retired_count, 32'd4);
        reset = 1'b0; #1;
        chk("to_cleared", 32'(fault), 32'd0);
        cyc(); reset = 1'b1; run = 1'b0; step = 1'b0;

        // multicycle ALU, alu_done 7 cycles after alu_start; step inside EXECUTE ignored
        cyc(); step = 1'b1; imem_ready = 1'b1; opcode = 5'h03; alu_multicycle = 1'b1;
        cyc(); step = 1'b0; #1;
        chk("mc_fetch", 32'(state), 32'd0);
        cyc(); #1;
        chk("mc_decode", 32'(state), 32'd1);
        for (int c = 3; c <= 10; c++) begin
            cyc(); step = (c == 5); alu_done = (c == 10); #1;
            chk("mc_exec_state", 32'(state), 32'd2);
            chk("mc_alu_start", 32'(alu_start), 32'(c == 3));
            chk("mc_no_pc", 32'(pc_enable), 32'd0);
        end
        cyc(); step = 1'b0; alu_done = 1'b0; #1;
        chk("mc_wb_state", 32'(state), 32'd3);
        chk("mc_wb_pc", 32'(pc_enable), 32'd1);
        cyc(); #1;
        chk("mc_idle", 32'(halted), 32'd1);
        repeat (3) cyc();
        #1;
        chk("mc_retired", retired_count, 32'd1);
        chk("mc_still_idle", 32'(halted), 32'd1);

        // HALT opcode under free-run returns to idle after DECODE, nothing retires
        cyc(); opcode = 5'h1F; alu_multicycle = 1'b0; run = 1'b1;
        cyc(); #1;
        chk("halt_fetch", 32'(ir_load), 32'd1);
        cyc(); #1;
        chk("halt_decode", 32'(state), 32'd1);
        chk("halt_no_pc", 32'(pc_enable), 32'd0);
        cyc(); run = 1'b0; #1;
        chk("halt_idle", 32'(halted), 32'd1);
        chk("halt_no_req", 32'(imem_req), 32'd0);
        repeat (2) cyc();
        #1;
        chk("halt_retired", retired_count, 32'd1);

        // reset in the middle of a multicycle EXECUTE
        cyc(); opcode = 5'h03; alu_multicycle = 1'b1; alu_done = 1'b0; step = 1'b1;
        cyc(); step = 1'b0;
        cyc(); cyc(); cyc(); #1;
        chk("rx_exec", 32'(state), 32'd2);
        reset = 1'b0; #1;
        chk("rx_halted", 32'(halted), 32'd1);
        chk("rx_strobes", {30'd0, pc_enable, reg_write_enable}, 32'd0);
        chk("rx_retired", retired_count, 32'd0);
        cyc(); alu_done = 1'b1; #1;
        chk("rx_hold_pc", 32'(pc_enable), 32'd0);
        cyc(); reset = 1'b1; alu_done = 1'b0; #1;
        chk("rx_release_idle", 32'(halted), 32'd1);
        cyc(); #1;
        chk("rx_stay_idle", 32'(halted), 32'd1);
        chk("rx_final_retired", retired_count, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Replaces the free-running 2-bit phase counter in the cpu with a handshaked instruction-cycle controller. It sequences FETCH/DECODE/EXECUTE/WRITE_BACK, and stalls on instruction-memory latency and multi-cycle ALU operations. It also supports run/halt and single-step debug, detects fetch timeouts, and counts retired instructions. It drives the pc_cntrl enable, regbank write enable, instruction-register load and ALU start strobes.

Parameters:
IMEM_TIMEOUT, 15, max cycles imem_req may wait for imem_ready before fault; 0 disables timeout
CNT_WIDTH, 32, width of retired-instruction counter

Ports:
clk  input  1  system clock, all flops on rising edge
reset  input  1  asynchronous, active-low reset
run  input  1  level; 1 = free-run instructions back to back
step  input  1  one-cycle pulse; executes exactly one instruction when idle and run=0
opcode  input  5  opcode field of latched instruction (inst[31:27])
no_write  input  1  decoded: instruction does not write a register (branch)
alu_multicycle  input  1  decoded: current opcode needs alu_done handshake
alu_done  input  1  ALU result valid (multi-cycle ops only)
imem_ready  input  1  instruction memory data valid this cycle
imem_req  output  1  fetch request to instruction memory
ir_load  output  1  latch instruction register this cycle
alu_start  output  1  one-cycle ALU start pulse
pc_enable  output  1  advance pc_cntrl this cycle
reg_write_enable  output  1  regbank write strobe
state  output  2  current phase encoded as `FETCH/`DECODE/`EXECUTE/`WRITE_BACK
halted  output  1  sequencer idle
fault  output  1  sticky fetch-timeout fault
retired_count  output  CNT_WIDTH  instructions completed through WRITE_BACK

Behaviour:
- Internal FSM states: IDLE, FETCH, DECODE, EXECUTE, WRITE_BACK, FAULT (3-bit register). The state output maps IDLE and FAULT to `FETCH.
- All strobe outputs decode combinationally from the registered FSM state and inputs, with no added latency. retired_count and the timeout counter are registered.
- Reset (reset=0, async): FSM=IDLE; timeout counter=0; retired_count=0. All strobes=0, halted=1, fault=0. Reset mid-instruction abandons the instruction; no write and no pc update occur.
- IDLE: halted=1. If run=1 or step=1 → FETCH next cycle. If both are 1, the step is absorbed (free-run). step is ignored in every other state.
- FETCH: imem_req=1 every cycle. In the cycle imem_ready=1, ir_load=1 and the next state is DECODE. If imem_ready=1 in the first FETCH cycle, FETCH lasts 1 cycle.
- Timeout: the counter increments on each FETCH cycle with imem_ready=0 and clears on leaving FETCH. When it reaches IMEM_TIMEOUT with IMEM_TIMEOUT≠0 → FAULT.
- DECODE: 1 cycle. If opcode==`HALT → IDLE, with no EXECUTE or WRITE_BACK, retired_count unchanged, and pc not advanced. Otherwise → EXECUTE.
- EXECUTE: alu_start=1 in the first EXECUTE cycle only, using a registered first-cycle flag.
  - alu_multicycle=0: 1 cycle, then → WRITE_BACK.
  - alu_multicycle=1: remain until alu_done=1, then → WRITE_BACK. alu_done in the alu_start cycle is accepted.
  - alu_done is ignored outside EXECUTE.
- WRITE_BACK: 1 cycle. pc_enable=1, reg_write_enable=!no_write, retired_count+1 (wraps modulo 2^CNT_WIDTH). Next state is FETCH if run=1, else IDLE.
- Deasserting run mid-instruction completes the current instruction through WRITE_BACK, then enters IDLE.
- FAULT: fault=1, halted=1, all strobes 0. Sticky until reset.
- Best-case throughput with single-cycle imem and ALU: 4 cycles per instruction.

Decomposition:
- Shared defines header (defines.vh) holds:
  - `FETCH/`DECODE/`EXECUTE/`WRITE_BACK phase codes (existing).
  - New `HALT opcode (5'h1F).
  - Internal FSM encodings `SEQ_IDLE…`SEQ_FAULT.
- One natural sub-module: seq_timeout, a loadable down-counter with clear/enable/expired, parameterised by IMEM_TIMEOUT.

Test Plan:
- Reset low, then high with run=0 → halted=1, state=`FETCH, all strobes 0, retired_count=0.
- run=1, imem_ready=1 always, alu_multicycle=0, 3 non-halt opcodes → pc_enable pulses every 4th cycle, 3 WRITE_BACKs, retired_count=3; with no_write=1 on the 2nd, reg_write_enable=0 in that WRITE_BACK only.
- imem_ready held 0 for 5 cycles → imem_req high 6 cycles, ir_load single pulse on cycle 6; with ready held 0 for 15 cycles (IMEM_TIMEOUT=15) → fault=1, stays 1 until reset.
- alu_multicycle=1, alu_done asserted 7 cycles after alu_start → alu_start exactly one cycle, EXECUTE lasts 8 cycles, then a single WRITE_BACK.
- run=0, single step pulse → exactly one instruction retires (retired_count +1), returns to IDLE; step during EXECUTE ignored; opcode=`HALT with run=1 → IDLE after DECODE, retired_count unchanged.
- reset asserted during EXECUTE of a multi-cycle op → immediate IDLE, no pc_enable/reg_write_enable pulse, retired_count=0.
